// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux sequencing controller.
package demux_sched_pkg;

    localparam int NUM_DST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [NUM_DST-1:0] onehot(input logic [1:0] idx);
        logic [NUM_DST-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_sched_rr_next_dst.sv
// Round-robin destination search: next set mask bit strictly after cur, wrapping 3->0.
module rr_next_dst
    import demux_sched_pkg::*;
(
    input  logic [NUM_DST-1:0] mask,
    input  logic [1:0]         cur,
    output logic [1:0]         nxt
);

    logic [1:0] cand;
    logic       found;

    // Offset NUM_DST wraps back onto cur itself, so a single-bit mask keeps its bit.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = cur;
        for (int i = 1; i <= NUM_DST; i++) begin
            cand = cur + 2'(i);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Deals a valid/ready vector stream out to up to four demux destinations in bursts,
// one frame of frame_len vectors per start pulse.
//
//   state | meaning
//   IDLE  | waiting for start; config checked and latched on start
//   RUN   | accepting vectors into the holding register, rotating destinations
//   DRAIN | last vector accepted; waiting for the holding register to empty
//   DONE  | one-cycle done pulse, then back to IDLE
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int array_size = 9,
    parameter int data_size  = 16,
    parameter int burst_w    = 8,
    parameter int count_w    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [burst_w-1:0]              burst_len,
    input  logic [count_w-1:0]              frame_len,
    input  logic [NUM_DST-1:0]              dst_mask,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [data_size*array_size-1:0] in_data,
    output logic [data_size*array_size-1:0] out_data,
    output logic [NUM_DST-1:0]              sel,
    output logic [NUM_DST-1:0]              out_valid,
    input  logic [NUM_DST-1:0]              out_ready
);

    localparam int VEC_W = data_size * array_size;

    state_e               state_q, state_d;
    logic [1:0]           cur_q, cur_d;
    logic [burst_w-1:0]   burst_cnt_q, burst_cnt_d;
    logic [count_w-1:0]   frame_cnt_q, frame_cnt_d;
    logic [burst_w-1:0]   burst_len_q, burst_len_d;
    logic [count_w-1:0]   frame_len_q, frame_len_d;
    logic [NUM_DST-1:0]   mask_q, mask_d;
    logic                 hold_q, hold_d;
    logic [NUM_DST-1:0]   sel_q, sel_d;
    logic [VEC_W-1:0]     out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 cfg_bad;
    logic                 drain;
    logic                 accept;
    logic                 in_ready_c;
    logic [burst_w-1:0]   burst_last;
    logic [count_w-1:0]   frame_last;
    logic [NUM_DST-1:0]   rr_mask;
    logic [1:0]           rr_cur;
    logic [1:0]           rr_nxt;

    // In IDLE, searching after index 3 yields the lowest set bit of the incoming mask.
    assign rr_mask = (state_q == IDLE) ? dst_mask : mask_q;
    assign rr_cur  = (state_q == IDLE) ? 2'd3 : cur_q;

    rr_next_dst u_rr_next_dst (
        .mask (rr_mask),
        .cur  (rr_cur),
        .nxt  (rr_nxt)
    );

    assign cfg_bad    = (dst_mask == '0) || (burst_len == '0) || (frame_len == '0);
    assign burst_last = burst_len_q - burst_w'(1);
    assign frame_last = frame_len_q - count_w'(1);
    assign drain      = hold_q && ((out_ready & sel_q) != '0);
    assign in_ready_c = (state_q == RUN) && (!hold_q || drain);
    assign accept     = in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
        frame_cnt_d = frame_cnt_q;
        burst_len_d = burst_len_q;
        frame_len_d = frame_len_q;
        mask_d      = mask_q;
        hold_d      = hold_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        cfg_err_d   = 1'b0;

        // An accept overrides a same-cycle drain so the register refills without a bubble.
        if (accept) begin
            out_data_d = in_data;
            sel_d      = onehot(cur_q);
            hold_d     = 1'b1;
        end else if (drain) begin
            hold_d = 1'b0;
            sel_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        burst_len_d = burst_len;
                        frame_len_d = frame_len;
                        mask_d      = dst_mask;
                        cur_d       = rr_nxt;
                        burst_cnt_d = '0;
                        frame_cnt_d = '0;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (burst_cnt_q == burst_last) begin
                        burst_cnt_d = '0;
                        cur_d       = rr_nxt;
                    end else begin
                        burst_cnt_d = burst_cnt_q + burst_w'(1);
                    end
                    if (frame_cnt_q == frame_last) begin
                        state_d = DRAIN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + count_w'(1);
                    end
                end
            end
            DRAIN: begin
                if (!hold_q || drain) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            burst_cnt_q <= '0;
            frame_cnt_q <= '0;
            burst_len_q <= '0;
            frame_len_q <= '0;
            mask_q      <= '0;
            hold_q      <= 1'b0;
            sel_q       <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            burst_len_q <= burst_len_d;
            frame_len_q <= frame_len_d;
            mask_q      <= mask_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign out_valid = hold_q ? sel_q : '0;

endmodule

// File: tb/tb_demux_sched.sv
// Self-checking bench for demux_sched: random frames scored against a destination-schedule model.
module tb_demux_sched;

    localparam int AS = 9;
    localparam int DS = 16;
    localparam int BW = 8;
    localparam int CW = 16;
    localparam int VW = AS * DS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic [CW-1:0] frame_len = '0;
    logic [3:0]    dst_mask = '0;
    logic          busy, done, cfg_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_data = '0;
    logic [VW-1:0] out_data;
    logic [3:0]    sel, out_valid;
    logic [3:0]    out_ready = '0;

    always #5 clk = ~clk;

    demux_sched #(.array_size(AS), .data_size(DS), .burst_w(BW), .count_w(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .frame_len(frame_len),
        .dst_mask(dst_mask), .busy(busy), .done(done), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_data(out_data), .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: enabled destinations in ascending order; vector j goes to list[(j/burst) % n].
    int            dst_list[$];
    logic [VW+3:0] sb_q[$];
    int cyc = 0, acc_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int first_acc_cyc = 0, last_acc_cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0;
    bit prev_valid = 0, prev_acc = 0;
    logic [3:0]    prev_xfer = '0, prev_sel = '0, prev_acc_sel = '0;
    logic [VW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_dst(input int j, input int b);
        return dst_list[(j / b) % dst_list.size()];
    endfunction

    task automatic setup_frame(input logic [3:0] m);
        dst_list.delete();
        for (int k = 0; k < 4; k++) if (m[k]) dst_list.push_back(k);
        sb_q.delete();
        acc_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    endtask

    task automatic cycle(input int b);
        logic [3:0]    xfer;
        logic [VW+3:0] e;
        logic [3:0]    s;
        #1;
        xfer = out_valid & out_ready;
        if (prev_acc) check("latency_valid", out_valid, prev_acc_sel);
        if (prev_valid && prev_xfer == 4'b0) begin
            check("hold_data", out_data, prev_data);
            check("hold_sel", sel, prev_sel);
        end
        if (out_valid != 4'b0 && xfer == 4'b0) check("in_ready_bp", in_ready, 0);
        if (xfer != 4'b0) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("out_data", out_data, e[VW-1:0]);
                check("sel", sel, e[VW+3:VW]);
            end
            check("out_valid_eq_sel", out_valid, sel);
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
        end
        prev_acc = 0;
        if (in_valid && in_ready) begin
            s = 4'(1 << exp_dst(acc_cnt, b));
            sb_q.push_back({s, in_data});
            prev_acc = 1;
            prev_acc_sel = s;
            if (acc_cnt == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_latency", cyc - last_xfer_cyc, 1);
            check("done_busy", busy, 0);
        end
        prev_valid = (out_valid != 4'b0);
        prev_xfer  = xfer;
        prev_data  = out_data;
        prev_sel   = sel;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1; start = 0; in_valid = 0; out_ready = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        cyc++;
        prev_valid = 0; prev_acc = 0; prev_xfer = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic run_frame(input logic [3:0] m, input int b, input int fl, input int vprob,
                             input int rprob, input int stall_at, input bit seq_data);
        int budget, stall_left;
        bit stalled_once, glitched;
        setup_frame(m);
        dst_mask = m; burst_len = BW'(b); frame_len = CW'(fl);
        start = 1; in_valid = 0; out_ready = '1;
        cycle(b);
        start = 0;
        check("busy_after_start", busy, 1);
        budget = fl * 30 + 100; stall_left = 0; stalled_once = 0; glitched = 0;
        while (done_cnt == 0 && budget > 0) begin
            if (!in_valid && acc_cnt < fl && $urandom_range(99) < vprob) begin
                in_valid = 1;
                in_data  = seq_data ? VW'(acc_cnt + 1) : VW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            end
            start = 0;
            if (acc_cnt == 1 && !glitched) begin
                start = 1; dst_mask = '0; burst_len = '0; frame_len = '0; glitched = 1;
            end
            if (stall_at >= 0 && acc_cnt == stall_at && !stalled_once) begin
                stall_left = 5; stalled_once = 1;
            end
            if (stall_left > 0) begin
                out_ready = '0;
                stall_left--;
            end else begin
                for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(99) < rprob);
            end
            check("cfg_err_in_run", cfg_err, 0);
            cycle(b);
            if (prev_acc) in_valid = 0;
            budget--;
        end
        start = 0; in_valid = 0;
        check("frame_done_seen", done_cnt, 1);
        check("accepted", acc_cnt, fl);
        check("transferred", xfer_cnt, fl);
        check("sb_empty", sb_q.size(), 0);
        cycle(b);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        if (vprob == 100 && rprob == 100 && stall_at < 0) begin
            check("no_bubble_in", last_acc_cyc - first_acc_cyc, fl - 1);
            check("no_bubble_out", last_xfer_cyc - first_xfer_cyc, fl - 1);
        end
    endtask

    initial begin
        int guard;
        do_reset();
        check_idle_outputs("reset");

        // Illegal configs: zero mask, zero burst, zero frame length
        for (int t = 0; t < 3; t++) begin
            dst_mask  = (t == 0) ? 4'b0 : 4'b1111;
            burst_len = (t == 1) ? BW'(0) : BW'(2);
            frame_len = (t == 2) ? CW'(0) : CW'(8);
            start = 1;
            cycle(1);
            start = 0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_busy", busy, 0);
            cycle(1);
            check("cfg_err_clear", cfg_err, 0);
            check("cfg_err_still_idle", busy, 0);
        end

        run_frame(4'b1111, 2, 8, 100, 100, -1, 1);
        run_frame(4'b1010, 3, 7, 100, 100, -1, 1);
        run_frame(4'b0001, 4, 12, 100, 100, 2, 0);
        run_frame(4'b1111, 3, 16, 100, 100, -1, 0);
        run_frame(4'b0100, 1, 5, 100, 100, -1, 0);
        for (int r = 0; r < 8; r++) begin
            run_frame(4'($urandom_range(15, 1)), $urandom_range(4, 1), $urandom_range(20, 1), 60, 60, -1, 0);
        end

        // Reset in the middle of a frame after three accepted vectors
        setup_frame(4'b1111);
        dst_mask = 4'b1111; burst_len = BW'(2); frame_len = CW'(8);
        start = 1; in_valid = 0; out_ready = '1;
        cycle(2);
        start = 0;
        guard = 0;
        while (acc_cnt < 3 && guard < 50) begin
            in_valid = 1;
            in_data  = VW'(acc_cnt + 100);
            cycle(2);
            guard++;
        end
        check("pre_reset_accepted", acc_cnt, 3);
        do_reset();
        check_idle_outputs("mid_reset");
        run_frame(4'b1111, 2, 8, 100, 100, -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Sequencing controller for the 1-to-4 vector demux array in the CNN datapath.
- Accepts a valid/ready stream of array_size-wide vectors and deals them out in bursts to up to four destination banks (e.g. PE kernel/feature buffers).
- Drives the demux data input and the one-hot select, and generates per-destination valid with backpressure.
- A frame of frame_len vectors is distributed per start pulse, rotating among enabled destinations every burst_len vectors.

Parameters:
- array_size, 9, elements per vector
- data_size, 16, bits per element
- burst_w, 8, width of burst_len
- count_w, 16, width of frame_len and internal frame counter

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and begins a frame
- burst_len  in  burst_w  vectors per destination before rotating
- frame_len  in  count_w  total vectors in frame
- dst_mask  in  4  enabled destinations, bit k = output k
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  one-cycle pulse when start carries an illegal config
- in_valid  in  1  input vector valid
- in_ready  out  1  input vector accepted when in_valid&&in_ready
- in_data  in  data_size*array_size  input vector
- out_data  out  data_size*array_size  to demux d_in
- sel  out  4  one-hot demux select, bit k routes to output k
- out_valid  out  4  per-destination valid, equals sel while holding
- out_ready  in  4  per-destination ready

Behaviour:
- Reset: state=IDLE; busy, done, cfg_err, in_ready, sel, out_valid = 0; out_data = 0; all counters 0, hold=0.
- Illegal config is dst_mask==0, burst_len==0 or frame_len==0.
- IDLE: in_ready=0.
  - start with legal config: latch config, cur = lowest set bit of dst_mask, burst_cnt=0, frame_cnt=0, go to RUN.
  - start with illegal config: cfg_err pulses next cycle; stay IDLE.
- RUN: single output holding register, flag hold.
  - in_ready = !hold || (out_ready & sel) != 0.
  - Accept cycle: out_data<=in_data, sel<=onehot(cur), hold<=1. Latency 1 cycle; throughput 1 vector/cycle when the destination is ready.
  - Drain without accept: hold<=0, sel<=0.
  - Simultaneous drain and accept in the same cycle: the new vector replaces the old; no bubble.
  - Burst: on accept, if burst_cnt==burst_len-1 then burst_cnt<=0 and cur<=next set bit of mask strictly after cur, wrapping 3->0. A single-bit mask stays on the same bit. Otherwise burst_cnt++.
  - Frame: on accept, if frame_cnt==frame_len-1 go to DRAIN; else frame_cnt++.
- DRAIN: in_ready=0; when hold clears (or is clear) go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- out_data and sel remain stable while hold=1 and the destination is not ready.
- out_valid = hold ? sel : 0. Bits of out_ready other than the selected one are ignored.
- start is ignored while busy or in DONE. Config inputs are ignored after latch.
- Reset mid-frame: everything returns to reset values next cycle; the in-flight vector is discarded.
- Counters compare against latched values minus 1, computed at burst_w/count_w width. Legal values never underflow.

Decomposition:
- Package demux_sched_pkg holds:
  - NUM_DST=4
  - state enum {IDLE, RUN, DRAIN, DONE}
  - onehot function (2-bit index to 4-bit)
- Sub-module rr_next_dst: combinational; inputs mask[4] and cur[2], output next index with wrap-around search.

Test Plan:
- Reset then idle: all outputs 0, in_ready=0; start with dst_mask=0 -> cfg_err pulse, busy stays 0.
- mask=4'b1111, burst_len=2, frame_len=8, always ready, streaming values 1..8 -> sel sequence 1,1,2,2,4,4,8,8 one cycle after each accept; done exactly 1 cycle after the last drain.
- mask=4'b1010, burst_len=3, frame_len=7 -> destinations 1,1,1,3,3,3,1.
- Backpressure: out_ready[0] low 5 cycles mid-burst -> out_data/sel stable, in_ready=0, no vector lost or duplicated; full throughput resumes once ready.
- Simultaneous drain+accept at full rate for 16 vectors -> 16 transfers in 16 consecutive cycles with no bubble.
- Reset asserted during RUN after 3 of 8 vectors -> next cycle IDLE, outputs 0; a new start runs a full 8-vector frame.
